bet_entry_sequencer: RTL and testbench
======================================

// Module: bet_entry_sequencer
// PURPOSE
//   Upstream feeder for the lottery checker core. Collects a player's ticket one digit at a time.
//   Rejects out-of-range and duplicate digits. Buffers NUM_DIGITS digits and, on confirm, replays
//   them to the core one per clock on numero/insere, then pulses fim_jogo to close the game.
// PARAMETERS
//   NUM_DIGITS  5   digits per ticket (buffer depth)
//   DIGIT_W     4   width of one digit
//   MAX_DIGIT   9   largest legal digit value; larger values are rejected
// PORTS
//   clock        in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   digit_in     in   DIGIT_W  digit offered by the keypad
//   digit_valid  in   1        one-cycle strobe: digit_in is valid this cycle
//   confirm      in   1        commit a full ticket and start playback
//   cancel       in   1        discard the digits collected so far
//   numero       out  DIGIT_W  digit presented to the core
//   insere       out  1        high while numero carries a ticket digit
//   fim_jogo     out  1        one-cycle end-of-game pulse after the last digit
//   count        out  3        number of digits currently stored (0..NUM_DIGITS)
//   busy         out  1        high in SEND and END states
//   err          out  1        one-cycle pulse: input rejected
// BEHAVIOUR
//   Reset (sync): state=COLLECT. numero=0, insere=0, fim_jogo=0, count=0, busy=0, err=0.
//     Buffer contents are don't-care.
//   Registered outputs. All responses appear on the clock edge after the triggering input.
//   FSM states: COLLECT -> FULL -> SEND -> END -> COLLECT.
//   COLLECT:
//     - digit_valid with digit_in <= MAX_DIGIT and digit_in not equal to any stored digit:
//       store at buf[count], count++.
//     - If count reaches NUM_DIGITS: go to FULL.
//     - digit_valid with digit_in > MAX_DIGIT, or a duplicate: err=1 for one cycle. Nothing stored.
//     - confirm in COLLECT: ignored, err=1.
//   FULL:
//     - digit_valid: ignored, err=1.
//     - confirm: go to SEND with index=0.
//   SEND (NUM_DIGITS cycles):
//     - numero=buf[index], insere=1, index++.
//     - First digit is valid on the edge after confirm was sampled.
//     - Digits are sent in entry order.
//     - After index NUM_DIGITS-1: go to END.
//   END (1 cycle): insere=0, numero=0, fim_jogo=1.
//     - Next cycle: COLLECT, count=0, fim_jogo=0.
//   Precedence:
//     - cancel in COLLECT or FULL: count=0, state=COLLECT. cancel beats digit_valid and confirm
//       in the same cycle.
//     - cancel, digit_valid and confirm during SEND/END: ignored. digit_valid also pulses err.
//     - digit_valid that fills the buffer, with confirm in the same cycle: digit stored, state=FULL,
//       confirm ignored. No err for that confirm.
//   Duplicate check compares only entries 0..count-1. Stale buffer contents never cause a rejection.
//   err is a pure pulse and never holds for two cycles off one strobe.
//   Reset mid-SEND: outputs are 0 on the next edge. No fim_jogo is emitted and the ticket is lost.
// TESTING
//   1. Enter 3,8,6,9,1 then confirm -> insere=1 for 5 cycles with numero 3,8,6,9,1, then fim_jogo=1
//      for 1 cycle, then count=0.
//   2. Enter 5 then 12 -> err pulses once, count stays 1. Enter 5 again -> err pulses,
//      count stays 1 (duplicate).
//   3. Enter 2,4 then confirm -> err=1, no insere. cancel -> count=0. Enter 0,1,2,3,4 -> count=5.
//   4. Full ticket 0,1,2,3,4 with cancel and confirm in the same cycle -> count=0, insere stays 0.
//   5. Assert reset during the 3rd SEND cycle -> next edge insere=0, numero=0. fim_jogo never pulses.
//   6. digit_valid=7 during SEND -> err pulse. Playback sequence and count unaffected.

Source files
------------

// File: rtl/bet_entry_sequencer.sv
// Keypad-to-checker feeder: collects a ticket of unique digits, then replays it to the core
// one digit per clock and closes the game with a single fim_jogo pulse.
module bet_entry_sequencer #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               confirm,
  input  logic               cancel,
  output logic [DIGIT_W-1:0] numero,
  output logic               insere,
  output logic               fim_jogo,
  output logic [2:0]         count,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {COLLECT, FULL, SEND, END} state_t;

  localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);
  localparam logic [2:0]         LAST     = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]         FULL_CNT = 3'(NUM_DIGITS);

  state_t             state, state_nxt;
  logic [2:0]         count_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [DIGIT_W-1:0] numero_nxt;
  logic               insere_nxt, fim_nxt, err_nxt;
  logic               wr_en, dup, accept;
  logic [DIGIT_W-1:0] digit_buf [NUM_DIGITS];

  assign busy = (state == SEND) || (state == END);

  // Only the live part of the buffer takes part in the duplicate check.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i < int'(count) && digit_buf[i] == digit_in) dup = 1'b1;
    end
    accept = digit_valid && (digit_in <= MAX_D) && !dup;
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    idx_nxt    = idx;
    numero_nxt = '0;
    insere_nxt = 1'b0;
    fim_nxt    = 1'b0;
    err_nxt    = 1'b0;
    wr_en      = 1'b0;
    case (state)
      COLLECT: begin
        if (cancel) begin
          count_nxt = '0;
        end else begin
          if (accept) begin
            wr_en     = 1'b1;
            count_nxt = count + 3'd1;
            if (count == LAST) state_nxt = FULL;
          end else if (digit_valid) begin
            err_nxt = 1'b1;
          end
          // A confirm arriving with the digit that completes the ticket is silently dropped.
          if (confirm && !(accept && count == LAST)) err_nxt = 1'b1;
        end
      end
      FULL: begin
        if (cancel) begin
          count_nxt = '0;
          state_nxt = COLLECT;
        end else begin
          err_nxt = digit_valid;
          if (confirm) begin
            state_nxt  = SEND;
            numero_nxt = digit_buf[0];
            insere_nxt = 1'b1;
            idx_nxt    = 3'd1;
          end
        end
      end
      SEND: begin
        err_nxt = digit_valid;
        if (idx == FULL_CNT) begin
          state_nxt = END;
          fim_nxt   = 1'b1;
        end else begin
          numero_nxt = digit_buf[idx];
          insere_nxt = 1'b1;
          idx_nxt    = idx + 3'd1;
        end
      end
      END: begin
        err_nxt   = digit_valid;
        state_nxt = COLLECT;
        count_nxt = '0;
        idx_nxt   = '0;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= COLLECT;
      count    <= '0;
      idx      <= '0;
      numero   <= '0;
      insere   <= 1'b0;
      fim_jogo <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      idx      <= idx_nxt;
      numero   <= numero_nxt;
      insere   <= insere_nxt;
      fim_jogo <= fim_nxt;
      err      <= err_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) digit_buf[count] <= digit_in;
  end

endmodule

// File: tb/tb_bet_entry_sequencer.sv
// Bench for bet_entry_sequencer: directed vector table, hand sequences for reset/SEND corner
// cases, and a randomized run against a queue-based ticket model.
module tb_bet_entry_sequencer;

  localparam int ND   = 5;
  localparam int DW   = 4;
  localparam int MAXD = 9;

  logic          clock = 1'b0;
  logic          reset, digit_valid, confirm, cancel;
  logic [DW-1:0] digit_in;
  logic [DW-1:0] numero;
  logic          insere, fim_jogo, busy, err;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  bet_entry_sequencer #(.NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_DIGIT(MAXD)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .confirm(confirm), .cancel(cancel), .numero(numero), .insere(insere),
    .fim_jogo(fim_jogo), .count(count), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit dv; logic [DW-1:0] din; bit cf; bit cn;
    logic [DW-1:0] num; bit ins; bit fim; logic [2:0] cnt; bit bsy; bit er;
  } vec_t;

  typedef struct { logic [DW-1:0] num; bit ins; bit fim; bit clr; } ev_t;

  // Reference model: the ticket is a queue of digits; playback is a queue of output events.
  logic [DW-1:0] ticket[$];
  ev_t           sched[$];
  logic [DW-1:0] m_num;
  bit            m_ins, m_fim, m_busy, m_err;
  logic [2:0]    m_cnt;

  task automatic model_step(input bit rst, input bit dv, input logic [DW-1:0] din,
                            input bit cf, input bit cn);
    ev_t e;
    bit  dup, acc;
    m_err = 0; m_num = '0; m_ins = 0; m_fim = 0;
    if (rst) begin
      ticket.delete(); sched.delete(); m_busy = 0;
    end else if (sched.size() > 0) begin
      m_err = dv;
      e = sched.pop_front();
      m_num = e.num; m_ins = e.ins; m_fim = e.fim; m_busy = !e.clr;
      if (e.clr) ticket.delete();
    end else begin
      m_busy = 0;
      if (cn) begin
        ticket.delete();
      end else if (ticket.size() == ND) begin
        m_err = dv;
        if (cf) begin
          foreach (ticket[i]) sched.push_back('{ticket[i], 1'b1, 1'b0, 1'b0});
          sched.push_back('{'0, 1'b0, 1'b1, 1'b0});
          sched.push_back('{'0, 1'b0, 1'b0, 1'b1});
          e = sched.pop_front();
          m_num = e.num; m_ins = 1; m_busy = 1;
        end
      end else begin
        dup = 0;
        foreach (ticket[i]) if (ticket[i] == din) dup = 1;
        acc = dv && (din <= MAXD) && !dup;
        if (dv && !acc) m_err = 1;
        if (acc) ticket.push_back(din);
        if (cf && !(acc && ticket.size() == ND)) m_err = 1;
      end
    end
    m_cnt = 3'(ticket.size());
  endtask

  task automatic check(input string tag, input logic [DW-1:0] en, input bit ei, input bit ef,
                       input logic [2:0] ec, input bit eb, input bit ee);
    checks++;
    if ({numero, insere, fim_jogo, count, busy, err} !== {en, ei, ef, ec, eb, ee}) begin
      errors++;
      $display("FAIL %s: got numero=%0d insere=%0b fim=%0b count=%0d busy=%0b err=%0b, expected numero=%0d insere=%0b fim=%0b count=%0d busy=%0b err=%0b",
               tag, numero, insere, fim_jogo, count, busy, err, en, ei, ef, ec, eb, ee);
    end
  endtask

  task automatic drive(input bit rst, input bit dv, input logic [DW-1:0] din,
                       input bit cf, input bit cn);
    @(negedge clock);
    reset = rst; digit_valid = dv; digit_in = din; confirm = cf; cancel = cn;
    @(posedge clock);
    model_step(rst, dv, din, cf, cn);
    #1;
  endtask

  task automatic step_model_check(input string tag, input bit rst, input bit dv,
                                  input logic [DW-1:0] din, input bit cf, input bit cn);
    drive(rst, dv, din, cf, cn);
    check(tag, m_num, m_ins, m_fim, m_cnt, m_busy, m_err);
  endtask

  function automatic vec_t v(bit rst, bit dv, int din, bit cf, bit cn,
                             int num, bit ins, bit fim, int cnt, bit bsy, bit er);
    vec_t r;
    r.rst = rst; r.dv = dv; r.din = DW'(din); r.cf = cf; r.cn = cn;
    r.num = DW'(num); r.ins = ins; r.fim = fim; r.cnt = 3'(cnt); r.bsy = bsy; r.er = er;
    return r;
  endfunction

  vec_t tbl[$];
  logic [DW-1:0] seen[$];
  int fim_cnt;

  initial begin
    reset = 1; digit_valid = 0; digit_in = '0; confirm = 0; cancel = 0;

    //            rst dv din cf cn   num ins fim cnt bsy err
    tbl.push_back(v(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    // ticket 3,8,6,9,1 and playback
    tbl.push_back(v(0, 1, 3, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 8, 0, 0,   0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 1, 6, 0, 0,   0, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 1, 9, 0, 0,   0, 0, 0, 4, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0,   0, 0, 0, 5, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0,   3, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   8, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   6, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   9, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   1, 1, 0, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 1, 5, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    // out-of-range and duplicate rejection
    tbl.push_back(v(0, 1, 5, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 12, 0, 0,  0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 5, 0, 0,   0, 0, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    // early confirm, cancel, refill
    tbl.push_back(v(0, 1, 2, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 4, 0, 0,   0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0,   0, 0, 0, 2, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    for (int d = 0; d < 5; d++) tbl.push_back(v(0, 1, d, 0, 0, 0, 0, 0, d + 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 5, 0, 0));
    // cancel beats confirm on a full ticket
    tbl.push_back(v(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    // stale buffer contents must not reject
    tbl.push_back(v(0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0,   0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    // confirm together with the filling digit is dropped without err
    tbl.push_back(v(0, 1, 5, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 1, 6, 0, 0,   0, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, 1, 7, 0, 0,   0, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, 1, 8, 0, 0,   0, 0, 0, 4, 0, 0));
    tbl.push_back(v(0, 1, 9, 1, 0,   0, 0, 0, 5, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0,   0, 0, 0, 5, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0,   0, 0, 0, 5, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    // range boundary just above MAX_DIGIT
    tbl.push_back(v(0, 1, 10, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 15, 0, 0,  0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].dv, tbl[i].din, tbl[i].cf, tbl[i].cn);
      check($sformatf("vec%0d", i), tbl[i].num, tbl[i].ins, tbl[i].fim, tbl[i].cnt,
            tbl[i].bsy, tbl[i].er);
    end

    // reset during the third SEND cycle
    step_model_check("rst_sync", 1, 0, 0, 0, 0);
    for (int d = 1; d <= 5; d++) step_model_check("rst_fill", 0, 1, DW'(d), 0, 0);
    step_model_check("rst_send1", 0, 0, 0, 1, 0);
    step_model_check("rst_send2", 0, 0, 0, 0, 0);
    step_model_check("rst_send3", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("rst_mid_send", '0, 0, 0, 3'd0, 0, 0);
    fim_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step_model_check("rst_after", 0, 0, 0, 0, 0);
      if (fim_jogo) fim_cnt++;
    end
    checks++;
    if (fim_cnt != 0) begin
      errors++;
      $display("FAIL rst_no_fim: got %0d fim pulses, expected 0", fim_cnt);
    end

    // digit strobe during playback
    seen.delete();
    for (int d = 0; d < 5; d++) step_model_check("snd_fill", 0, 1, DW'(2 * d + 1), 0, 0);
    drive(0, 0, 0, 1, 0);
    check("snd_first", m_num, m_ins, m_fim, m_cnt, m_busy, m_err);
    if (insere) seen.push_back(numero);
    for (int k = 0; k < 6; k++) begin
      drive(0, k == 1, 4'd7, k == 2, k == 3);
      check("snd_strobe", m_num, m_ins, m_fim, m_cnt, m_busy, m_err);
      if (insere) seen.push_back(numero);
    end
    checks++;
    if (seen != '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9}) begin
      errors++;
      $display("FAIL snd_order: got %0d digits %p, expected 1,3,5,7,9", seen.size(), seen);
    end
    step_model_check("snd_done", 0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      bit r, dv, cf, cn;
      logic [DW-1:0] din;
      r   = ($urandom_range(0, 199) == 0);
      dv  = ($urandom_range(0, 1) == 1);
      din = ($urandom_range(0, 9) == 0) ? DW'($urandom_range(10, 15)) : DW'($urandom_range(0, 9));
      cf  = ($urandom_range(0, 6) == 0);
      cn  = ($urandom_range(0, 39) == 0);
      step_model_check($sformatf("rnd%0d", k), r, dv, din, cf, cn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
